// File: rtl/muldiv_unit_pkg.sv
// Shared opt codes, FSM state type and opt-decoding helpers for the
// iterative multiply/divide sequencer.
package muldiv_unit_pkg;

  localparam int MULDIV_OPT_WIDTH = 3;

  localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MULT  = 3'd0;
  localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MULTU = 3'd1;
  localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_DIV   = 3'd2;
  localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_DIVU  = 3'd3;
  localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MTHI  = 3'd4;
  localparam logic [MULDIV_OPT_WIDTH-1:0] MULDIV_OPT_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic opt_is_iter(input logic [MULDIV_OPT_WIDTH-1:0] o);
    return (o == MULDIV_OPT_MULT) || (o == MULDIV_OPT_MULTU) ||
           (o == MULDIV_OPT_DIV)  || (o == MULDIV_OPT_DIVU);
  endfunction

  function automatic logic opt_is_known(input logic [MULDIV_OPT_WIDTH-1:0] o);
    return opt_is_iter(o) || (o == MULDIV_OPT_MTHI) || (o == MULDIV_OPT_MTLO);
  endfunction

  function automatic logic opt_is_div(input logic [MULDIV_OPT_WIDTH-1:0] o);
    return (o == MULDIV_OPT_DIV) || (o == MULDIV_OPT_DIVU);
  endfunction

  function automatic logic opt_is_signed(input logic [MULDIV_OPT_WIDTH-1:0] o);
    return (o == MULDIV_OPT_MULT) || (o == MULDIV_OPT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration: add-then-shift-right for multiply, or
// shift-left/trial-subtract (restoring) for divide, on a shared accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_is_div,
  output logic [2*WIDTH:0]   o_acc,
  output logic               o_q_bit
);

  // Multiply layout: {upper[WIDTH:0], multiplier[WIDTH-1:0]}.
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH:0] w_mul_acc;

  assign w_sum     = i_acc[2*WIDTH:WIDTH] + (i_acc[0] ? {1'b0, i_operand} : '0);
  assign w_mul_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};

  // Divide layout: {remainder[WIDTH:0], dividend/quotient[WIDTH-1:0]}.
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;
  logic [2*WIDTH:0] w_div_acc;

  assign w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = {1'b0, w_rem_sh} - {2'b00, i_operand};
  assign w_borrow  = w_diff[WIDTH+1];
  // The vacated LSB is left zero; the sequencer ORs in o_q_bit.
  assign w_div_acc = {(w_borrow ? w_rem_sh : w_diff[WIDTH:0]), i_acc[WIDTH-2:0], 1'b0};

  assign o_acc   = i_is_div ? w_div_acc : w_mul_acc;
  assign o_q_bit = i_is_div & ~w_borrow;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also services
// MTHI/MTLO. Handshake: start is accepted only while busy=0 and cancel=0.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MULDIV_OPT_WIDTH-1:0] opt,
  input  logic [WIDTH-1:0]            opr1,
  input  logic [WIDTH-1:0]            opr2,
  input  logic                        cancel,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            hi,
  output logic [WIDTH-1:0]            lo,
  output logic                        illegal_opt,
  output state_t                      o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_next;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd, r_hi, r_lo, r_raw1;
  logic             r_is_div, r_neg_q, r_neg_r, r_div0, r_done, r_illegal;

  logic w_idle, w_accept, w_go, w_bad, w_mthi, w_mtlo;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = start & w_idle & ~cancel;
  assign w_go     = w_accept & opt_is_iter(opt);
  assign w_bad    = w_accept & ~opt_is_known(opt);
  assign w_mthi   = w_accept & (opt == MULDIV_OPT_MTHI);
  assign w_mtlo   = w_accept & (opt == MULDIV_OPT_MTLO);

  // Operand magnitudes; only the signed ops look at the sign bits.
  logic             w_signed, w_neg1, w_neg2, w_div_op;
  logic [WIDTH-1:0] w_mag1, w_mag2;
  assign w_signed = opt_is_signed(opt);
  assign w_div_op = opt_is_div(opt);
  assign w_neg1   = w_signed & opr1[WIDTH-1];
  assign w_neg2   = w_signed & opr2[WIDTH-1];
  assign w_mag1   = w_neg1 ? (~opr1 + 1'b1) : opr1;
  assign w_mag2   = w_neg2 ? (~opr2 + 1'b1) : opr2;

  logic [AW-1:0] w_step_acc;
  logic          w_q_bit;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .i_is_div  (r_is_div),
    .o_acc     (w_step_acc),
    .o_q_bit   (w_q_bit)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_next = ST_CALC;
      ST_CALC: begin
        if (cancel)                w_next = ST_IDLE;
        else if (r_count == LAST)  w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Sign fix-up of the raw magnitude results.
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;
  always_comb begin
    w_prod   = r_acc[2*WIDTH-1:0];
    w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    w_quo    = r_acc[WIDTH-1:0];
    w_rem    = r_acc[2*WIDTH-1:WIDTH];
    w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_s[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_lo = DIV0_LO;
        w_res_hi = r_raw1;
      end else begin
        w_res_lo = r_neg_q ? (~w_quo + 1'b1) : w_quo;
        w_res_hi = r_neg_r ? (~w_rem + 1'b1) : w_rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_raw1    <= '0;
      r_count   <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= w_bad;
      if (w_mthi) r_hi <= opr1;
      if (w_mtlo) r_lo <= opr1;
      if (w_go) begin
        r_acc    <= {{(WIDTH+1){1'b0}}, (w_div_op ? w_mag1 : w_mag2)};
        r_opnd   <= w_div_op ? w_mag2 : w_mag1;
        r_is_div <= w_div_op;
        r_neg_q  <= w_neg1 ^ w_neg2;
        r_neg_r  <= w_neg1;
        r_div0   <= (opr2 == '0);
        r_raw1   <= opr1;
        r_count  <= '0;
      end else if ((r_state == ST_CALC) && !cancel) begin
        r_acc   <= w_step_acc | {{(AW-1){1'b0}}, w_q_bit};
        r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
      end else if ((r_state == ST_FIX) && !cancel) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end
    end
  end

  assign busy        = ~w_idle;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign illegal_opt = r_illegal;
  assign o_dbg_state = r_state;

endmodule
